// File: rtl/shift_xcvr_if.sv
// Bundle of the shift engine's control, parallel and serial signals.
// The slave modport is the engine's view; master is the driving side.
interface shift_xcvr_if #(
   parameter int WIDTH = 8
);
   logic                           start;
   logic [WIDTH-1:0]               din;
   logic                           msb_first;
   logic                           shift_en;
   logic                           sin;
   logic                           sout;
   logic [WIDTH-1:0]               dout;
   logic                           busy;
   logic                           eos;
   logic [$clog2(WIDTH+1)-1:0]     bit_cnt;

   modport slave (
      input  start, din, msb_first, shift_en, sin,
      output sout, dout, busy, eos, bit_cnt
   );

   modport master (
      output start, din, msb_first, shift_en, sin,
      input  sout, dout, busy, eos, bit_cnt
   );
endinterface

// File: rtl/shift_xcvr.sv
// Full-duplex WIDTH-bit shift engine: loads a word, shifts it out on sout
// while capturing sin, then pulses eos and publishes the received word.
module shift_xcvr #(
   parameter int   WIDTH      = 8,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   shift_xcvr_if.slave bus
);
   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] sreg_r;
   logic [WIDTH-1:0] shifted_s;
   logic [WIDTH-1:0] dout_r;
   logic [CW-1:0]    cnt_r;
   logic             ord_r;
   logic             busy_r;
   logic             eos_r;
   logic             sout_r;

   function automatic logic out_bit(input logic [WIDTH-1:0] w, input logic msb);
      return msb ? w[WIDTH-1] : w[0];
   endfunction

   // Register value after one shift tick in the captured order.
   always_comb begin
      shifted_s = {WIDTH{1'b0}};
      if (ord_r) begin
         shifted_s = {sreg_r[WIDTH-2:0], bus.sin};
      end else begin
         shifted_s = {bus.sin, sreg_r[WIDTH-1:1]};
      end
   end

   // Transfer FSM; sout is precomputed from the next register value so it stays registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         sreg_r  <= {WIDTH{1'b0}};
         dout_r  <= {WIDTH{1'b0}};
         cnt_r   <= {CW{1'b0}};
         ord_r   <= 1'b0;
         busy_r  <= 1'b0;
         eos_r   <= 1'b0;
         sout_r  <= IDLE_LEVEL;
      end else begin
         case (state_r)
            IDLE: begin
               eos_r <= 1'b0;
               if (bus.start) begin
                  sreg_r  <= bus.din;
                  ord_r   <= bus.msb_first;
                  cnt_r   <= {CW{1'b0}};
                  sout_r  <= out_bit(bus.din, bus.msb_first);
                  busy_r  <= 1'b1;
                  state_r <= SHIFT;
               end else begin
                  sout_r  <= IDLE_LEVEL;
                  busy_r  <= 1'b0;
               end
            end
            SHIFT: begin
               if (bus.shift_en) begin
                  sreg_r <= shifted_s;
                  cnt_r  <= cnt_r + CW'(1);
                  if (cnt_r == LAST) begin
                     dout_r  <= shifted_s;
                     eos_r   <= 1'b1;
                     sout_r  <= IDLE_LEVEL;
                     state_r <= DONE;
                  end else begin
                     sout_r  <= out_bit(shifted_s, ord_r);
                  end
               end else begin
                  sreg_r <= sreg_r;
               end
            end
            DONE: begin
               cnt_r   <= {CW{1'b0}};
               eos_r   <= 1'b0;
               busy_r  <= 1'b0;
               sout_r  <= IDLE_LEVEL;
               state_r <= IDLE;
            end
            default: begin
               cnt_r   <= {CW{1'b0}};
               eos_r   <= 1'b0;
               busy_r  <= 1'b0;
               sout_r  <= IDLE_LEVEL;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.sout    = sout_r;
   assign bus.dout    = dout_r;
   assign bus.busy    = busy_r;
   assign bus.eos     = eos_r;
   assign bus.bit_cnt = cnt_r;
endmodule

// File: tb/tb_shift_xcvr.sv
// Scoreboard bench for shift_xcvr: the driver queues expected serial bits and
// received words from a word-level model; an independent monitor checks them.
module tb_shift_xcvr;
   localparam int   W  = 8;
   localparam logic IL = 1'b1;

   logic clk = 1'b0;
   logic rst_n;
   logic loop_mode;
   logic sin_drv;

   int n_pass = 0;
   int n_chk  = 0;
   int cyc    = 0;
   int last_busy_len = 0;

   logic         exp_bits[$];
   logic [W-1:0] exp_dout[$];
   int           eos_q[$];

   shift_xcvr_if #(.WIDTH(W)) bus ();

   assign bus.sin = loop_mode ? bus.sout : sin_drv;

   shift_xcvr #(.WIDTH(W), .IDLE_LEVEL(IL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic fail(input string nm);
      n_chk++;
      $display("FAIL %s: event not expected by the model (cycle %0d)", nm, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Word-level model: serial order of din and the word assembled from sin bits.
   task automatic push_model(input logic [W-1:0] d, input logic m, input bit lp,
                             input logic [W-1:0] pat);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         exp_bits.push_back(m ? d[W-1-i] : d[i]);
         if (m) r[W-1-i] = pat[i];
         else   r[i]     = pat[i];
      end
      exp_dout.push_back(lp ? d : r);
   endtask

   // pat[i] is the i-th bit placed on sin; period>0 ticks every period-th cycle.
   task automatic xfer(input logic [W-1:0] d, input logic m, input bit lp,
                       input logic [W-1:0] pat, input int period, input bit rnd,
                       input bit pulse);
      int ticks;
      int c;
      push_model(d, m, lp, pat);
      loop_mode     = lp;
      bus.start     = 1'b1;
      bus.din       = d;
      bus.msb_first = m;
      bus.shift_en  = 1'b1;
      step();
      bus.din       = W'($urandom);
      bus.msb_first = ~m;
      ticks = 0;
      c = 0;
      while (ticks < W && c < 2000) begin
         if (rnd) bus.shift_en = ($urandom_range(0, 2) != 0);
         else     bus.shift_en = ((c % period) == (period - 1));
         sin_drv   = pat[ticks];
         bus.start = pulse && (ticks == 3);
         if (pulse) bus.din = 8'hFF;
         step();
         if (bus.shift_en) ticks++;
         c++;
      end
      if (c >= 2000) fail("xfer_timeout");
      bus.start    = pulse;
      bus.din      = 8'hFF;
      bus.shift_en = 1'b1;
      step();
      bus.start    = 1'b0;
      bus.shift_en = 1'b0;
   endtask

   // Monitor: compares each shifted bit, each completed word and idle behaviour.
   initial begin
      logic eos_prev;
      logic stall_prev;
      logic sout_prev;
      int   seen;
      int   blen;
      eos_prev = 1'b0; stall_prev = 1'b0; sout_prev = 1'b0; seen = 0; blen = 0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            seen = 0; blen = 0; stall_prev = 1'b0; eos_prev = 1'b0;
         end else begin
            if (bus.busy) blen++;
            else if (blen != 0) begin last_busy_len = blen; blen = 0; end
            if (bus.busy && !bus.eos) begin
               chk("bit_cnt", 32'(bus.bit_cnt), 32'(seen));
               if (stall_prev) chk("stall_hold", 32'(bus.sout), 32'(sout_prev));
               if (bus.shift_en) begin
                  if (exp_bits.size() == 0) fail("unexpected_shift");
                  else chk("sout", 32'(bus.sout), 32'(exp_bits.pop_front()));
                  seen++;
               end
               stall_prev = !bus.shift_en;
            end else if (bus.eos) begin
               chk("eos_len", 32'(eos_prev), 32'(0));
               chk("done_busy", 32'(bus.busy), 32'(1));
               chk("done_cnt", 32'(bus.bit_cnt), 32'(W));
               chk("done_sout", 32'(bus.sout), 32'(IL));
               if (exp_dout.size() == 0) fail("unexpected_eos");
               else chk("dout", 32'(bus.dout), 32'(exp_dout.pop_front()));
               eos_q.push_back(cyc);
               seen = 0;
               stall_prev = 1'b0;
            end else begin
               chk("idle_sout", 32'(bus.sout), 32'(IL));
               chk("idle_cnt", 32'(bus.bit_cnt), 32'(0));
               seen = 0;
               stall_prev = 1'b0;
            end
            eos_prev  = bus.eos;
            sout_prev = bus.sout;
         end
      end
   end

   initial begin
      logic [W-1:0] bd[3];
      logic         bm[3];
      rst_n = 1'b0; loop_mode = 1'b0; sin_drv = 1'b0;
      bus.start = 1'b0; bus.din = '0; bus.msb_first = 1'b0; bus.shift_en = 1'b0;
      repeat (2) step();
      chk("rst_busy", 32'(bus.busy), 32'(0));
      chk("rst_eos", 32'(bus.eos), 32'(0));
      chk("rst_cnt", 32'(bus.bit_cnt), 32'(0));
      chk("rst_dout", 32'(bus.dout), 32'(0));
      chk("rst_sout", 32'(bus.sout), 32'(IL));
      rst_n = 1'b1;
      step();

      xfer(8'hC1, 1'b1, 1'b1, 8'h00, 1, 1'b0, 1'b0);
      step();
      chk("t1_busy_len", 32'(last_busy_len), 32'(W + 1));
      chk("t1_dout", 32'(bus.dout), 32'h0000_00C1);

      xfer(8'hC1, 1'b0, 1'b0, 8'h5A, 1, 1'b0, 1'b0);
      step();
      chk("t2_dout", 32'(bus.dout), 32'h0000_005A);

      xfer(8'hF0, 1'b1, 1'b1, 8'h00, 3, 1'b0, 1'b0);
      step();
      chk("t3_dout", 32'(bus.dout), 32'h0000_00F0);

      xfer(8'h96, 1'b1, 1'b1, 8'h00, 1, 1'b0, 1'b1);
      repeat (3) step();
      chk("t4_dout", 32'(bus.dout), 32'h0000_0096);
      chk("t4_busy", 32'(bus.busy), 32'(0));

      for (int i = 0; i < W; i++) exp_bits.push_back(i[0] == 1'b0);
      loop_mode = 1'b1; bus.start = 1'b1; bus.din = 8'hAA; bus.msb_first = 1'b1;
      step();
      bus.start = 1'b0; bus.shift_en = 1'b1;
      repeat (4) step();
      rst_n = 1'b0; bus.shift_en = 1'b0;
      step();
      rst_n = 1'b1;
      exp_bits.delete();
      chk("t5_busy", 32'(bus.busy), 32'(0));
      chk("t5_eos", 32'(bus.eos), 32'(0));
      chk("t5_cnt", 32'(bus.bit_cnt), 32'(0));
      chk("t5_dout", 32'(bus.dout), 32'(0));
      chk("t5_sout", 32'(bus.sout), 32'(IL));
      repeat (12) step();
      xfer(8'h3C, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0);
      step();
      chk("t5_dout_new", 32'(bus.dout), 32'h0000_003C);

      eos_q.delete();
      for (int i = 0; i < 3; i++) begin
         bd[i] = W'($urandom);
         bm[i] = 1'($urandom);
         push_model(bd[i], bm[i], 1'b1, 8'h00);
      end
      loop_mode = 1'b1; bus.shift_en = 1'b1; bus.start = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (c % 10 == 0) begin
            bus.din       = bd[c / 10];
            bus.msb_first = bm[c / 10];
         end
         step();
      end
      bus.start = 1'b0;
      repeat (12) step();
      bus.shift_en = 1'b0;
      chk("b2b_eos_count", 32'(eos_q.size()), 32'(3));
      for (int i = 1; i < eos_q.size(); i++)
         chk("b2b_spacing", 32'(eos_q[i] - eos_q[i-1]), 32'(W + 2));

      for (int n = 0; n < 12; n++) begin
         xfer(W'($urandom), 1'($urandom), 1'($urandom), W'($urandom), 1, 1'b1, 1'b0);
         repeat ($urandom_range(0, 2)) step();
      end

      repeat (4) step();
      chk("drain_bits", 32'(exp_bits.size()), 32'(0));
      chk("drain_dout", 32'(exp_dout.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/shift_xcvr.md
Name: shift_xcvr

Overview:
Parametrised full-duplex shift engine. It is the next generation of the 8-bit parallel-in/serial-out shifter used behind the tt_um top wrappers. Each transfer loads a WIDTH-bit word and shifts it out on sout while sampling sin into the same register. Shifting can be MSB-first or LSB-first and is paced by a shift-enable tick. At completion the block pulses eos and presents the received word on dout. It sits between top-level pins (ui_in/uio) and a serial peripheral or loopback.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
IDLE_LEVEL, 1'b0, value driven on sout while not shifting.

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  transfer request, sampled only in IDLE
din  input  WIDTH  parallel word to transmit, captured on accepted start
msb_first  input  1  shift order, captured on accepted start (1 = MSB first)
shift_en  input  1  shift tick; one bit transferred per cycle with shift_en=1 in SHIFT
sin  input  1  serial data in, sampled on shift ticks
sout  output  1  serial data out, driven from registers only
dout  output  WIDTH  last completed received word
busy  output  1  high in SHIFT and DONE
eos  output  1  end-of-shift, one-cycle pulse in DONE
bit_cnt  output  $clog2(WIDTH+1)  bits shifted in current transfer

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a rising edge), from any state including mid-transfer:
  - state=IDLE; sreg=0; bit_cnt=0; dout=0; busy=0; eos=0; sout=IDLE_LEVEL.
  - A partial transfer is discarded; dout is not updated.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, eos=0, sout=IDLE_LEVEL.
  - start=1 at an edge: sreg<=din; ord<=msb_first; bit_cnt<=0; state<=SHIFT.
  - shift_en in the same cycle as start has no effect.
- SHIFT:
  - busy=1.
  - sout = ord ? sreg[WIDTH-1] : sreg[0]. The first bit appears in the cycle after start is accepted.
  - Edge with shift_en=1:
    - ord=1: sreg<={sreg[WIDTH-2:0],sin}.
    - ord=0: sreg<={sin,sreg[WIDTH-1:1]}.
    - bit_cnt<=bit_cnt+1.
  - Edge with shift_en=0: everything holds (stall of any length, sout stable).
  - On the shift edge where bit_cnt==WIDTH-1:
    - dout<=shifted sreg value (the complete received word).
    - bit_cnt<=WIDTH; state<=DONE.
- DONE:
  - Lasts exactly one cycle. eos=1, busy=1, sout=IDLE_LEVEL, dout shows the new word.
  - Next edge: state<=IDLE, bit_cnt<=0.
  - start in DONE is ignored; it is not queued.
- start while busy: ignored. din and msb_first changes during a transfer: no effect.
- Latency with shift_en held at 1:
  - start accepted at edge k; shifts at edges k+1..k+WIDTH; DONE in cycle after edge k+WIDTH.
  - Minimum start-to-start spacing: WIDTH+2 cycles.
- dout holds its value until the next completed transfer or reset.
- Bit-width rules: bit_cnt never exceeds WIDTH and never wraps.

Test Plan:
1. Reset, WIDTH=8, start with din=0xC1, msb_first=1, shift_en=1, sin looped from sout -> sout over 8 cycles = 1,1,0,0,0,0,0,1; eos high exactly 1 cycle; dout=0xC1; busy high 9 cycles.
2. din=0xC1, msb_first=0, sin tied to the pattern 0,1,0,1,1,0,1,0 (LSB first) -> sout = 1,0,0,0,0,0,1,1; dout=0x5A.
3. shift_en=1 only every 3rd cycle, din=0xF0 MSB first, loopback -> each sout bit held 3 cycles; eos follows the 8th tick; dout=0xF0; bit_cnt steps 0..8.
4. start pulsed again during SHIFT and during DONE with din=0xFF -> ignored; the first transfer completes unchanged; the block returns to IDLE with sout=IDLE_LEVEL.
5. rst_n=0 for 1 cycle after 4 bits of a transfer of din=0xAA -> next cycle busy=0, eos=0, bit_cnt=0, dout=0, sout=IDLE_LEVEL; no eos occurs; a fresh start with din=0x3C loopback gives dout=0x3C.
6. Back-to-back: start held high continuously with shift_en=1 -> transfers accepted every 10 cycles (WIDTH+2); eos pulses spaced 10 cycles apart.
